viterbi_stream_arbiter: RTL and testbench
=========================================

# viterbi_stream_arbiter

Packet-granular arbiter that shares one ATSC Viterbi decoder (the HLS `atsc_viterbi_impl` core) between two AXI-stream requesters in the ce_clk domain.
- It grants whole input packets round-robin and records each grant (port ID plus 128-bit CVITA header) in a tag FIFO.
- It routes decoder output packets back to the originating port, in order, with the matching header.
- It sits between the `axi_wrapper` instances and the decoder inside the Viterbi NoC block.

## Interface
- WIDTH, 32, tdata width of all streams.
- TAG_DEPTH_LOG2, 3, log2 of the tag FIFO depth. Default allows 8 packets in flight inside the decoder.
- ce_clk  in  1  sole clock.
- ce_rst  in  1  reset; synchronous, active-high.
- s0_tdata/s0_tuser/s0_tlast/s0_tvalid, s0_tready  in/in/in/in, out  WIDTH/128/1/1, 1  requester 0 input packet stream with header.
- s1_*  same as s0_*  requester 1.
- dec_in_tdata/tlast/tvalid  out  WIDTH/1/1  to decoder input.
- dec_in_tready  in  1  decoder input ready.
- dec_out_tdata/tlast/tvalid  in  WIDTH/1/1  from decoder output.
- dec_out_tready  out  1  decoder output ready.
- m0_tdata/m0_tuser/m0_tlast/m0_tvalid, m0_tready  out, in  WIDTH/128/1/1, 1  output stream to requester 0.
- m1_*  same as m0_*  output stream to requester 1.
- enable  in  2  per-port grant enable; bit n enables port n.
- pkt_in_cnt0, pkt_in_cnt1  out  16  packets accepted per port; wraps at 16 bits.
- pkt_out_cnt0, pkt_out_cnt1  out  16  packets delivered per port; wraps at 16 bits.
- orphan_err  out  1  sticky: decoder presented output while the tag FIFO was empty.

## Operation
- Input FSM states: IDLE, GRANT0, GRANT1. last_grant register resets to 1, so port 0 wins first.
- In IDLE, a port is eligible when its `enable` bit is 1 and its tvalid is 1. The FSM evaluates eligibility only when the tag FIFO is not full.
- Both ports eligible: grant the port != last_grant. One port eligible: grant it.
- On grant, in the same IDLE cycle:
  - push tag {port, sN_tuser} into the tag FIFO;
  - go to GRANTN;
  - set last_grant = N.
- In GRANTN, the granted port passes through combinationally: dec_in_* = sN_*, and sN_tready = dec_in_tready. The other port sees tready = 0.
- An accepted beat with tlast in GRANTN increments pkt_in_cntN and returns the FSM to IDLE.
- The FSM holds s0_tready = s1_tready = 0 and dec_in_tvalid = 0 in IDLE.
- Output router, tag FIFO non-empty: the head tag port P selects the destination. mP_tdata/tlast/tvalid = dec_out_*, mP_tuser = head header, and dec_out_tready = mP_tready. The non-selected m port has tvalid = 0.
- An accepted output beat with tlast pops the tag and increments pkt_out_cntP.
- Tag FIFO empty: dec_out_tready = 0. If dec_out_tvalid = 1 in that state, set orphan_err; only reset clears it.
- Tag FIFO push and pop in the same cycle are legal at any occupancy. The push side never fires when full.
- An `enable` change takes effect at the next IDLE evaluation only. It never aborts a granted packet.

## Timing
- Reset values: FSM IDLE, tag FIFO empty, last_grant = 1, all counters 0, orphan_err 0. All tready and tvalid outputs are 0, and tdata/tuser outputs are 0.
- A reset mid-packet discards the partial packet and all tags. Upstream blocks and the decoder are reset by the same ce_rst.
- Input path overhead: exactly one bubble cycle (the grant cycle) per packet. After that, data latency is 0 cycles, fully combinational.
- Output path latency: 0 cycles. Routing for a packet is fixed by the head tag for its whole duration.
- The tag FIFO is full at 2^TAG_DEPTH_LOG2 entries. A packet already granted completes even when its push made the FIFO full.
- Handshakes are AXI-stream: a beat transfers when valid && ready on a rising ce_clk edge. Valid never depends on ready.
- Counters wrap 0xFFFF -> 0x0000.

## Test plan
- Single port: enable = 01, three 4-word packets on s0 -> they appear on dec_in with one idle cycle between packets. Loopback output reaches m0 with the matching tuser; pkt_in_cnt0 = pkt_out_cnt0 = 3, and m1_tvalid never rises.
- Contention: both ports always valid with 8-word packets, enable = 11 -> grants alternate 0,1,0,1. Outputs route to m0,m1,m0,m1 with the correct headers.
- Tag FIFO full: decoder output held (m0_tready = 0) with TAG_DEPTH_LOG2 = 3 -> exactly 8 packets are granted and the 9th sees s_tready = 0. One output packet drains -> the 9th is granted the cycle after the pop.
- Backpressure: random dec_in_tready and m_tready over 200 packets -> no lost or duplicated beats, and data and per-port ordering match the reference model.
- Orphan output: dec_out_tvalid = 1 with the FIFO empty -> dec_out_tready = 0 and orphan_err = 1 from the next cycle until ce_rst.
- Mid-packet reset: ce_rst asserted on beat 3 of a granted packet -> the next cycle shows the FSM in IDLE, all readies 0, counters 0. The following packet is processed normally.

Source files
------------

// File: rtl/viterbi_stream_arbiter.sv
// Shares one Viterbi decoder between two AXI-stream requesters: whole packets are granted
// round-robin, and a tag FIFO of {port, header} routes decoder output back in order.
module viterbi_stream_arbiter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TAG_DEPTH_LOG2 = 3
) (
  input  logic             i_ce_clk,
  input  logic             i_ce_rst,
  input  logic [WIDTH-1:0] i_s0_tdata,
  input  logic [127:0]     i_s0_tuser,
  input  logic             i_s0_tlast,
  input  logic             i_s0_tvalid,
  output logic             o_s0_tready,
  input  logic [WIDTH-1:0] i_s1_tdata,
  input  logic [127:0]     i_s1_tuser,
  input  logic             i_s1_tlast,
  input  logic             i_s1_tvalid,
  output logic             o_s1_tready,
  output logic [WIDTH-1:0] o_dec_in_tdata,
  output logic             o_dec_in_tlast,
  output logic             o_dec_in_tvalid,
  input  logic             i_dec_in_tready,
  input  logic [WIDTH-1:0] i_dec_out_tdata,
  input  logic             i_dec_out_tlast,
  input  logic             i_dec_out_tvalid,
  output logic             o_dec_out_tready,
  output logic [WIDTH-1:0] o_m0_tdata,
  output logic [127:0]     o_m0_tuser,
  output logic             o_m0_tlast,
  output logic             o_m0_tvalid,
  input  logic             i_m0_tready,
  output logic [WIDTH-1:0] o_m1_tdata,
  output logic [127:0]     o_m1_tuser,
  output logic             o_m1_tlast,
  output logic             o_m1_tvalid,
  input  logic             i_m1_tready,
  input  logic [1:0]       i_enable,
  output logic [15:0]      o_pkt_in_cnt0,
  output logic [15:0]      o_pkt_in_cnt1,
  output logic [15:0]      o_pkt_out_cnt0,
  output logic [15:0]      o_pkt_out_cnt1,
  output logic             o_orphan_err
);

  localparam int unsigned Depth = 1 << TAG_DEPTH_LOG2;
  localparam int unsigned CntW  = TAG_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e                    r_state, w_state_d;
  logic                      r_last_grant, w_last_grant_d;
  logic [128:0]              r_tag_mem [Depth];
  logic [TAG_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]           r_count;
  logic [15:0]               r_in_cnt0, r_in_cnt1, r_out_cnt0, r_out_cnt1;
  logic                      r_orphan;

  logic         w_full, w_empty, w_elig0, w_elig1;
  logic         w_push, w_push_port, w_pop;
  logic         w_in_done0, w_in_done1;
  logic         w_head_port;
  logic [127:0] w_head_user;
  logic         w_dec_out_tready;

  assign w_full      = (r_count == CntW'(Depth));
  assign w_empty     = (r_count == '0);
  assign w_head_port = r_tag_mem[r_rd_ptr][128];
  assign w_head_user = r_tag_mem[r_rd_ptr][127:0];
  assign w_elig0     = i_enable[0] & i_s0_tvalid;
  assign w_elig1     = i_enable[1] & i_s1_tvalid;

  // Input side: grant in IDLE, then pass the granted port straight through to the decoder.
  always_comb begin
    w_state_d       = r_state;
    w_last_grant_d  = r_last_grant;
    w_push          = 1'b0;
    w_push_port     = 1'b0;
    w_in_done0      = 1'b0;
    w_in_done1      = 1'b0;
    o_s0_tready     = 1'b0;
    o_s1_tready     = 1'b0;
    o_dec_in_tdata  = '0;
    o_dec_in_tlast  = 1'b0;
    o_dec_in_tvalid = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_full && (w_elig0 || w_elig1)) begin
          w_push         = 1'b1;
          w_push_port    = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;
          w_last_grant_d = w_push_port;
          w_state_d      = w_push_port ? StGrant1 : StGrant0;
        end
      end
      StGrant0: begin
        o_dec_in_tdata  = i_s0_tdata;
        o_dec_in_tlast  = i_s0_tlast;
        o_dec_in_tvalid = i_s0_tvalid;
        o_s0_tready     = i_dec_in_tready;
        w_in_done0      = i_s0_tvalid & i_dec_in_tready & i_s0_tlast;
        if (w_in_done0) w_state_d = StIdle;
      end
      StGrant1: begin
        o_dec_in_tdata  = i_s1_tdata;
        o_dec_in_tlast  = i_s1_tlast;
        o_dec_in_tvalid = i_s1_tvalid;
        o_s1_tready     = i_dec_in_tready;
        w_in_done1      = i_s1_tvalid & i_dec_in_tready & i_s1_tlast;
        if (w_in_done1) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output side: the head tag owns the decoder output until its tlast beat is accepted.
  always_comb begin
    o_m0_tdata       = '0;
    o_m0_tuser       = '0;
    o_m0_tlast       = 1'b0;
    o_m0_tvalid      = 1'b0;
    o_m1_tdata       = '0;
    o_m1_tuser       = '0;
    o_m1_tlast       = 1'b0;
    o_m1_tvalid      = 1'b0;
    w_dec_out_tready = 1'b0;
    if (!w_empty) begin
      if (w_head_port) begin
        o_m1_tdata       = i_dec_out_tdata;
        o_m1_tuser       = w_head_user;
        o_m1_tlast       = i_dec_out_tlast;
        o_m1_tvalid      = i_dec_out_tvalid;
        w_dec_out_tready = i_m1_tready;
      end else begin
        o_m0_tdata       = i_dec_out_tdata;
        o_m0_tuser       = w_head_user;
        o_m0_tlast       = i_dec_out_tlast;
        o_m0_tvalid      = i_dec_out_tvalid;
        w_dec_out_tready = i_m0_tready;
      end
    end
  end

  assign o_dec_out_tready = w_dec_out_tready;
  assign w_pop            = w_dec_out_tready & i_dec_out_tvalid & i_dec_out_tlast;

  always_ff @(posedge i_ce_clk) begin
    if (i_ce_rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_in_cnt0    <= '0;
      r_in_cnt1    <= '0;
      r_out_cnt0   <= '0;
      r_out_cnt1   <= '0;
      r_orphan     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_last_grant <= w_last_grant_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_in_done0)            r_in_cnt0  <= r_in_cnt0 + 16'd1;
      if (w_in_done1)            r_in_cnt1  <= r_in_cnt1 + 16'd1;
      if (w_pop && !w_head_port) r_out_cnt0 <= r_out_cnt0 + 16'd1;
      if (w_pop && w_head_port)  r_out_cnt1 <= r_out_cnt1 + 16'd1;
      if (w_empty && i_dec_out_tvalid) r_orphan <= 1'b1;
    end
  end

  always_ff @(posedge i_ce_clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= {w_push_port, w_push_port ? i_s1_tuser : i_s0_tuser};
  end

  assign o_pkt_in_cnt0  = r_in_cnt0;
  assign o_pkt_in_cnt1  = r_in_cnt1;
  assign o_pkt_out_cnt0 = r_out_cnt0;
  assign o_pkt_out_cnt1 = r_out_cnt1;
  assign o_orphan_err   = r_orphan;

endmodule

// File: tb/tb_viterbi_stream_arbiter.sv
// Randomised bench for viterbi_stream_arbiter: per-port packet queues, a loopback decoder
// model and in-order per-port expectations checked on every delivered beat.
module tb_viterbi_stream_arbiter;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0][31:0]  s_tdata;
  logic [1:0][127:0] s_tuser;
  logic [1:0]        s_tlast, s_tvalid, s_tready;
  logic [31:0]       dec_in_tdata, dec_out_tdata;
  logic              dec_in_tlast, dec_in_tvalid, dec_in_tready;
  logic              dec_out_tlast, dec_out_tvalid, dec_out_tready;
  logic [1:0][31:0]  m_tdata;
  logic [1:0][127:0] m_tuser;
  logic [1:0]        m_tlast, m_tvalid, m_tready;
  logic [1:0]        enable;
  logic [1:0][15:0]  in_cnt, out_cnt;
  logic              orphan;

  always #5 clk = ~clk;

  viterbi_stream_arbiter #(.WIDTH(32), .TAG_DEPTH_LOG2(3)) dut (
    .i_ce_clk(clk), .i_ce_rst(rst),
    .i_s0_tdata(s_tdata[0]), .i_s0_tuser(s_tuser[0]), .i_s0_tlast(s_tlast[0]),
    .i_s0_tvalid(s_tvalid[0]), .o_s0_tready(s_tready[0]),
    .i_s1_tdata(s_tdata[1]), .i_s1_tuser(s_tuser[1]), .i_s1_tlast(s_tlast[1]),
    .i_s1_tvalid(s_tvalid[1]), .o_s1_tready(s_tready[1]),
    .o_dec_in_tdata(dec_in_tdata), .o_dec_in_tlast(dec_in_tlast),
    .o_dec_in_tvalid(dec_in_tvalid), .i_dec_in_tready(dec_in_tready),
    .i_dec_out_tdata(dec_out_tdata), .i_dec_out_tlast(dec_out_tlast),
    .i_dec_out_tvalid(dec_out_tvalid), .o_dec_out_tready(dec_out_tready),
    .o_m0_tdata(m_tdata[0]), .o_m0_tuser(m_tuser[0]), .o_m0_tlast(m_tlast[0]),
    .o_m0_tvalid(m_tvalid[0]), .i_m0_tready(m_tready[0]),
    .o_m1_tdata(m_tdata[1]), .o_m1_tuser(m_tuser[1]), .o_m1_tlast(m_tlast[1]),
    .o_m1_tvalid(m_tvalid[1]), .i_m1_tready(m_tready[1]),
    .i_enable(enable),
    .o_pkt_in_cnt0(in_cnt[0]), .o_pkt_in_cnt1(in_cnt[1]),
    .o_pkt_out_cnt0(out_cnt[0]), .o_pkt_out_cnt1(out_cnt[1]),
    .o_orphan_err(orphan)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  beat_t src_q [2][$];
  beat_t exp_q [2][$];
  beat_t dec_q [$];
  int    grants [$];
  int    grant_cyc [$];
  logic [1:0] src_first;
  int    s_fires [2];
  int    sent [2];
  int    m_pct [2];
  int    src_pct, din_pct, dout_pct;
  logic  din_first, m1_seen, force_dout, gap_chk;
  int    prev_last_cyc, last_pop_cyc;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    b.user = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    sent[p]++;
  endtask

  // Sample every handshake at the negedge, then drive the next input values after posedge.
  task automatic step();
    logic [1:0] f_s, f_m;
    logic       f_din, f_dout;
    beat_t      b;
    @(negedge clk);
    cyc++;
    f_s    = s_tvalid & s_tready;
    f_m    = m_tvalid & m_tready;
    f_din  = dec_in_tvalid & dec_in_tready;
    f_dout = dec_out_tvalid & dec_out_tready;
    if (m_tvalid[1]) m1_seen = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (f_s[p] && src_q[p].size() != 0) begin
        if (src_first[p]) begin
          grants.push_back(p);
          grant_cyc.push_back(cyc);
        end
        src_first[p] = src_q[p][0].last;
        s_fires[p]++;
        void'(src_q[p].pop_front());
      end
      if (f_m[p]) begin
        check("m_beat_expected", exp_q[p].size() != 0, 1);
        if (exp_q[p].size() != 0) begin
          b = exp_q[p].pop_front();
          check("m_beat", {m_tlast[p], m_tuser[p], m_tdata[p]}, b);
        end
        if (m_tlast[p]) last_pop_cyc = cyc;
      end
    end
    if (f_dout && dec_q.size() != 0) void'(dec_q.pop_front());
    if (f_din) begin
      if (gap_chk && din_first && prev_last_cyc >= 0) check("in_gap", cyc - prev_last_cyc, 2);
      din_first = dec_in_tlast;
      if (dec_in_tlast) prev_last_cyc = cyc;
      b = '{last: dec_in_tlast, user: '0, data: dec_in_tdata};
      dec_q.push_back(b);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (!(s_tvalid[p] && !f_s[p])) begin
        s_tvalid[p] = (src_q[p].size() != 0) && (($urandom % 100) < src_pct);
        if (s_tvalid[p]) {s_tlast[p], s_tuser[p], s_tdata[p]} = src_q[p][0];
      end
      m_tready[p] = ($urandom % 100) < m_pct[p];
    end
    dec_in_tready = ($urandom % 100) < din_pct;
    if (force_dout) begin
      dec_out_tvalid = 1'b1;
    end else if (!(dec_out_tvalid && !f_dout && dec_q.size() != 0)) begin
      dec_out_tvalid = (dec_q.size() != 0) && (($urandom % 100) < dout_pct);
      if (dec_out_tvalid) {dec_out_tlast, dec_out_tdata} = {dec_q[0].last, dec_q[0].data};
    end
  endtask

  task automatic clear_models();
    for (int p = 0; p < 2; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      s_fires[p] = 0;
      sent[p]    = 0;
    end
    src_first      = 2'b11;
    s_tvalid       = 2'b00;
    dec_q.delete();
    grants.delete();
    grant_cyc.delete();
    dec_out_tvalid = 1'b0;
    din_first      = 1'b1;
    prev_last_cyc  = -1;
    last_pop_cyc   = -1;
    m1_seen        = 1'b0;
    force_dout     = 1'b0;
    gap_chk        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_models();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_pct(input int src, input int din, input int dout, input int m0, input int m1);
    src_pct  = src;
    din_pct  = din;
    dout_pct = dout;
    m_pct[0] = m0;
    m_pct[1] = m1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((src_q[0].size() + src_q[1].size() + dec_q.size() + exp_q[0].size()
            + exp_q[1].size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, n < budget, 1);
    #3;
  endtask

  initial begin
    int n;
    int pop0;
    rst = 1'b1;
    enable = 2'b00;
    s_tdata = '0; s_tuser = '0; s_tlast = '0; s_tvalid = '0;
    dec_in_tready = 1'b0; dec_out_tdata = '0; dec_out_tlast = 1'b0; dec_out_tvalid = 1'b0;
    m_tready = '0;
    set_pct(100, 100, 100, 100, 100);
    do_reset();

    // Reset state
    #3;
    check("rst_s_tready", s_tready, 0);
    check("rst_dec_in", {dec_in_tvalid, dec_in_tlast, dec_in_tdata}, 0);
    check("rst_dec_out_tready", dec_out_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_data", {m_tdata, m_tuser, m_tlast}, 0);
    check("rst_counters", {in_cnt, out_cnt}, 0);
    check("rst_orphan", orphan, 0);

    // Single port: one bubble cycle per packet, everything returns on m0
    do_reset();
    enable = 2'b01;
    gap_chk = 1'b1;
    for (int k = 0; k < 3; k++) add_pkt(0, 4);
    drain("single_drain", 200);
    check("single_in_cnt0", in_cnt[0], 3);
    check("single_out_cnt0", out_cnt[0], 3);
    check("single_m1_quiet", m1_seen, 0);
    check("single_cnt1", {in_cnt[1], out_cnt[1]}, 0);

    // Contention: grants alternate starting with port 0
    do_reset();
    enable = 2'b11;
    for (int k = 0; k < 4; k++) begin
      add_pkt(0, 8);
      add_pkt(1, 8);
    end
    drain("cont_drain", 400);
    check("cont_grant_cnt", grants.size(), 8);
    for (int i = 0; i < grants.size(); i++) check("cont_grant_order", grants[i], i % 2);
    check("cont_counters", {in_cnt[0], in_cnt[1], out_cnt[0], out_cnt[1]}, {4{16'd4}});

    // Tag FIFO full: 8 granted, 9th waits until one output packet pops
    do_reset();
    enable = 2'b01;
    set_pct(100, 100, 100, 0, 100);
    for (int k = 0; k < 9; k++) add_pkt(0, 2);
    for (int i = 0; i < 60; i++) step();
    #3;
    check("full_in_cnt0", in_cnt[0], 8);
    check("full_grants", grants.size(), 8);
    check("full_s0_stall", {s_tvalid[0], s_tready[0]}, 2'b10);
    m_pct[0] = 100;
    n = 0;
    while (last_pop_cyc < 0 && n < 20) begin step(); n++; end
    check("full_pop_seen", last_pop_cyc >= 0, 1);
    pop0 = last_pop_cyc;
    n = 0;
    while (grants.size() < 9 && n < 20) begin step(); n++; end
    check("full_9th_granted", grants.size(), 9);
    if (grants.size() == 9) check("full_9th_timing", grant_cyc[8] - pop0, 2);
    drain("full_drain", 200);
    check("full_counters", {in_cnt[0], out_cnt[0]}, {16'd9, 16'd9});

    // Backpressure: 200 random packets under random readies
    do_reset();
    enable = 2'b11;
    set_pct(70, 60, 70, 60, 55);
    for (int k = 0; k < 200; k++) add_pkt($urandom % 2, 1 + ($urandom % 6));
    drain("bp_drain", 30000);
    check("bp_in_cnt", {in_cnt[0], in_cnt[1]}, {16'(sent[0]), 16'(sent[1])});
    check("bp_out_cnt", {out_cnt[0], out_cnt[1]}, {16'(sent[0]), 16'(sent[1])});

    // Orphan decoder output
    set_pct(100, 100, 100, 100, 100);
    do_reset();
    force_dout = 1'b1;
    step();
    #3;
    check("orphan_no_ready", {dec_out_tvalid, dec_out_tready}, 2'b10);
    check("orphan_not_yet", orphan, 0);
    step();
    #3;
    check("orphan_set", orphan, 1);
    force_dout = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #3;
    check("orphan_sticky", orphan, 1);
    do_reset();
    #3;
    check("orphan_cleared", orphan, 0);

    // Mid-packet reset on beat 3
    enable = 2'b01;
    add_pkt(0, 6);
    n = 0;
    while (s_fires[0] < 2 && n < 20) begin step(); n++; end
    check("midrst_two_beats", s_fires[0], 2);
    rst = 1'b1;
    step();
    clear_models();
    rst = 1'b0;
    #3;
    check("midrst_readies", {s_tready, dec_out_tready, dec_in_tvalid}, 0);
    check("midrst_counters", {in_cnt, out_cnt}, 0);
    add_pkt(0, 4);
    drain("midrst_drain", 200);
    check("midrst_after", {in_cnt[0], out_cnt[0]}, {16'd1, 16'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
